// File: rtl/lt_arb_pkg.sv
// Shared types for the link-training AUX arbiter: FSM states, owner ids, request payload.
package lt_arb_pkg;

  localparam int unsigned TIMEOUT_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK
  } state_e;

  typedef enum logic {
    OWN_CR,
    OWN_EQ
  } owner_e;

  typedef struct packed {
    logic [7:0]  data;
    logic [19:0] address;
    logic [7:0]  len;
    logic [1:0]  cmd;
  } aux_req_t;

endpackage

// File: rtl/lt_arb_req_slot.sv
// One-entry request slot: captures a strobed transaction and holds it pending until cleared.
module lt_arb_req_slot
  import lt_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     vld_i,
  input  aux_req_t req_i,
  input  logic     clr_i,
  output logic     pend_o,
  output aux_req_t req_o,
  output logic     drop_c_o
);

  logic     pend_q, pend_d;
  aux_req_t req_q, req_d;
  logic     accept_c;

  // Clear is applied before set, so a strobe on the clearing cycle is accepted.
  always_comb begin
    pend_d   = pend_q;
    req_d    = req_q;
    accept_c = vld_i && (!pend_q || clr_i);
    drop_c_o = vld_i && pend_q && !clr_i;
    if (clr_i) begin
      pend_d = 1'b0;
    end
    if (accept_c) begin
      pend_d = 1'b1;
      req_d  = req_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      req_q  <= '0;
    end else begin
      pend_q <= pend_d;
      req_q  <= req_d;
    end
  end

  assign pend_o = pend_q;
  assign req_o  = req_q;

endmodule

// File: rtl/lt_aux_arbiter.sv
// Round-robin arbiter of the AUX transaction port between the CR and EQ link-training FSMs.
// LT_ARB_TIMEOUT_EN compiles in the WAIT_ACK timeout counter and its local-failure path.
module lt_aux_arbiter
  import lt_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cr_data,
  input  logic [19:0] cr_address,
  input  logic [7:0]  cr_len,
  input  logic [1:0]  cr_cmd,
  input  logic        cr_transaction_vld,
  input  logic [7:0]  eq_data,
  input  logic [19:0] eq_address,
  input  logic [7:0]  eq_len,
  input  logic [1:0]  eq_cmd,
  input  logic        eq_transaction_vld,
  input  logic        ctrl_ack_flag,
  input  logic        ctrl_native_failed,
  output logic [7:0]  lt_data,
  output logic [19:0] lt_address,
  output logic [7:0]  lt_len,
  output logic [1:0]  lt_cmd,
  output logic        lt_transaction_vld,
  output logic        cr_ack_flag,
  output logic        cr_native_failed,
  output logic        eq_ack_flag,
  output logic        eq_native_failed,
  output logic        lt_busy,
  output logic        arb_drop
);

  if ((TIMEOUT_CYCLES < 32'd2) || (TIMEOUT_CYCLES > ((32'd1 << TIMEOUT_W) - 32'd1))) begin : g_bad_timeout
    $error("lt_aux_arbiter: TIMEOUT_CYCLES out of range");
  end

  aux_req_t cr_req_c, eq_req_c, cr_slot, eq_slot;
  logic     cr_pend, eq_pend, cr_drop_c, eq_drop_c, cr_clr_c, eq_clr_c;
  logic     timeout_c;
  owner_e   grant_c;

  state_e   state_q, state_d;
  owner_e   last_owner_q, last_owner_d;
  aux_req_t lt_q, lt_d;
  logic     vld_q, vld_d, busy_q, busy_d, drop_q, drop_d;
  logic     cr_ack_q, cr_ack_d, cr_fail_q, cr_fail_d;
  logic     eq_ack_q, eq_ack_d, eq_fail_q, eq_fail_d;

  assign cr_req_c = {cr_data, cr_address, cr_len, cr_cmd};
  assign eq_req_c = {eq_data, eq_address, eq_len, eq_cmd};

  // The slot is released on the cycle its response pulse is driven.
  assign cr_clr_c = cr_ack_q | cr_fail_q;
  assign eq_clr_c = eq_ack_q | eq_fail_q;

  lt_arb_req_slot u_cr_slot (
    .clk      (clk),
    .rst      (rst),
    .vld_i    (cr_transaction_vld),
    .req_i    (cr_req_c),
    .clr_i    (cr_clr_c),
    .pend_o   (cr_pend),
    .req_o    (cr_slot),
    .drop_c_o (cr_drop_c)
  );

  lt_arb_req_slot u_eq_slot (
    .clk      (clk),
    .rst      (rst),
    .vld_i    (eq_transaction_vld),
    .req_i    (eq_req_c),
    .clr_i    (eq_clr_c),
    .pend_o   (eq_pend),
    .req_o    (eq_slot),
    .drop_c_o (eq_drop_c)
  );

`ifdef LT_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT_ACK) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_c = (state_q == WAIT_ACK) && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 32'd1));
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    grant_c = OWN_EQ;
    if (cr_pend && eq_pend) begin
      grant_c = (last_owner_q == OWN_EQ) ? OWN_CR : OWN_EQ;
    end else if (cr_pend) begin
      grant_c = OWN_CR;
    end
  end

  // IDLE holds off while a slot is still being released so it cannot be re-granted.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    lt_d         = lt_q;
    vld_d        = 1'b0;
    cr_ack_d     = 1'b0;
    cr_fail_d    = 1'b0;
    eq_ack_d     = 1'b0;
    eq_fail_d    = 1'b0;
    drop_d       = cr_drop_c | eq_drop_c;
    case (state_q)
      IDLE: begin
        if ((cr_pend || eq_pend) && !cr_clr_c && !eq_clr_c) begin
          state_d      = ISSUE;
          last_owner_d = grant_c;
          lt_d         = (grant_c == OWN_CR) ? cr_slot : eq_slot;
          vld_d        = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ctrl_native_failed || timeout_c) begin
          cr_fail_d = (last_owner_q == OWN_CR);
          eq_fail_d = (last_owner_q == OWN_EQ);
          state_d   = IDLE;
        end else if (ctrl_ack_flag) begin
          cr_ack_d = (last_owner_q == OWN_CR);
          eq_ack_d = (last_owner_q == OWN_EQ);
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_EQ;
      lt_q         <= '0;
      vld_q        <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
      cr_ack_q     <= 1'b0;
      cr_fail_q    <= 1'b0;
      eq_ack_q     <= 1'b0;
      eq_fail_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      lt_q         <= lt_d;
      vld_q        <= vld_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
      cr_ack_q     <= cr_ack_d;
      cr_fail_q    <= cr_fail_d;
      eq_ack_q     <= eq_ack_d;
      eq_fail_q    <= eq_fail_d;
    end
  end

  assign lt_data            = lt_q.data;
  assign lt_address         = lt_q.address;
  assign lt_len             = lt_q.len;
  assign lt_cmd             = lt_q.cmd;
  assign lt_transaction_vld = vld_q;
  assign cr_ack_flag        = cr_ack_q;
  assign cr_native_failed   = cr_fail_q;
  assign eq_ack_flag        = eq_ack_q;
  assign eq_native_failed   = eq_fail_q;
  assign lt_busy            = busy_q;
  assign arb_drop           = drop_q;

endmodule

// File: tb/tb_lt_aux_arbiter.sv
// Bench for lt_aux_arbiter: directed vector table, corner-case sequences and a random run
// against a transaction-level reference model. Timeout checks depend on LT_ARB_TIMEOUT_EN.
module tb_lt_aux_arbiter;
  import lt_arb_pkg::*;

  localparam int unsigned TO = 8;
`ifdef LT_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk, rst;
  logic [7:0]  cr_data, eq_data, lt_data, cr_len, eq_len, lt_len;
  logic [19:0] cr_address, eq_address, lt_address;
  logic [1:0]  cr_cmd, eq_cmd, lt_cmd;
  logic        cr_transaction_vld, eq_transaction_vld, ctrl_ack_flag, ctrl_native_failed;
  logic        lt_transaction_vld, cr_ack_flag, cr_native_failed, eq_ack_flag, eq_native_failed;
  logic        lt_busy, arb_drop;

  int n_tests = 0;
  int n_fail  = 0;

  lt_aux_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cr_data(cr_data), .cr_address(cr_address), .cr_len(cr_len), .cr_cmd(cr_cmd),
    .cr_transaction_vld(cr_transaction_vld),
    .eq_data(eq_data), .eq_address(eq_address), .eq_len(eq_len), .eq_cmd(eq_cmd),
    .eq_transaction_vld(eq_transaction_vld),
    .ctrl_ack_flag(ctrl_ack_flag), .ctrl_native_failed(ctrl_native_failed),
    .lt_data(lt_data), .lt_address(lt_address), .lt_len(lt_len), .lt_cmd(lt_cmd),
    .lt_transaction_vld(lt_transaction_vld),
    .cr_ack_flag(cr_ack_flag), .cr_native_failed(cr_native_failed),
    .eq_ack_flag(eq_ack_flag), .eq_native_failed(eq_native_failed),
    .lt_busy(lt_busy), .arb_drop(arb_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // Output bit order: vld, cr_ack, cr_fail, eq_ack, eq_fail, busy, drop
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_VLD  = 7'b1000010;
  localparam logic [6:0] O_BUSY = 7'b0000010;
  localparam logic [6:0] O_CRA  = 7'b0100000;
  localparam logic [6:0] O_CRF  = 7'b0010000;
  localparam logic [6:0] O_EQF  = 7'b0000100;
  localparam logic [6:0] O_DROP = 7'b0000001;

  function automatic logic [6:0] outs();
    return {lt_transaction_vld, cr_ack_flag, cr_native_failed, eq_ack_flag, eq_native_failed,
            lt_busy, arb_drop};
  endfunction

  function automatic aux_req_t lt_now();
    return {lt_data, lt_address, lt_len, lt_cmd};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic cv, input aux_req_t cr_r, input logic ev, input aux_req_t eq_r,
                       input logic a, input logic f);
    cr_transaction_vld = cv;
    {cr_data, cr_address, cr_len, cr_cmd} = cr_r;
    eq_transaction_vld = ev;
    {eq_data, eq_address, eq_len, eq_cmd} = eq_r;
    ctrl_ack_flag      = a;
    ctrl_native_failed = f;
  endtask

  // Apply inputs for one clock, then check the registered outputs that result.
  task automatic step(input string nm, input logic cv, input aux_req_t cr_r, input logic ev,
                      input aux_req_t eq_r, input logic a, input logic f,
                      input logic [6:0] eo, input aux_req_t elt);
    drive(cv, cr_r, ev, eq_r, a, f);
    @(negedge clk);
    chk({nm, "_out"}, 64'(outs()), 64'(eo));
    chk({nm, "_lt"}, 64'(lt_now()), 64'(elt));
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: pending flags, stored requests and the age of the active transaction.
  int       m_pend[2];
  aux_req_t m_req[2];
  int       m_last;  // 0 = CR, 1 = EQ
  int       m_age;   // -1 none, 0 issue cycle, k>=1 k-th cycle waiting for a response
  logic [3:0] m_rsp; // cr_ack, cr_fail, eq_ack, eq_fail
  logic     m_vld, m_drop;
  aux_req_t m_lt;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0;
      m_req[k]  = '0;
    end
    m_last = 1; m_age = -1; m_rsp = '0; m_vld = 1'b0; m_drop = 1'b0; m_lt = '0;
  endtask

  task automatic model_step();
    logic [1:0] clr, sv;
    aux_req_t   in_r[2];
    logic [3:0] n_rsp;
    int         g;
    clr[0]  = m_rsp[3] | m_rsp[2];
    clr[1]  = m_rsp[1] | m_rsp[0];
    sv      = {eq_transaction_vld, cr_transaction_vld};
    in_r[0] = {cr_data, cr_address, cr_len, cr_cmd};
    in_r[1] = {eq_data, eq_address, eq_len, eq_cmd};
    n_rsp   = '0;
    m_vld   = 1'b0;
    m_drop  = 1'b0;
    if (m_age >= 1) begin
      if (ctrl_native_failed || (TO_EN && (m_age == int'(TO)))) begin
        n_rsp = (m_last == 0) ? 4'b0100 : 4'b0001;
        m_age = -1;
      end else if (ctrl_ack_flag) begin
        n_rsp = (m_last == 0) ? 4'b1000 : 4'b0010;
        m_age = -1;
      end else begin
        m_age++;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if ((m_pend[0] != 0 || m_pend[1] != 0) && clr == 2'b00) begin
      g = (m_pend[0] != 0 && m_pend[1] != 0) ? 1 - m_last : (m_pend[0] != 0 ? 0 : 1);
      m_last = g;
      m_lt   = m_req[g];
      m_vld  = 1'b1;
      m_age  = 0;
    end
    for (int k = 0; k < 2; k++) begin
      if (sv[k] && m_pend[k] != 0 && !clr[k]) begin
        m_drop = 1'b1;
      end else if (sv[k]) begin
        m_pend[k] = 1;
        m_req[k]  = in_r[k];
      end else if (clr[k]) begin
        m_pend[k] = 0;
      end
    end
    m_rsp = n_rsp;
  endtask

  typedef struct {
    logic       cv;
    aux_req_t   cr_r;
    logic       ev;
    aux_req_t   eq_r;
    logic       a;
    logic       f;
    logic [6:0] eo;
    aux_req_t   elt;
  } vec_t;

  vec_t     tv[17];
  aux_req_t ra, rb, rc, rd, re1, re2, re3, rf, z;
  int       busy_cnt;

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    z   = '0;
    ra  = {8'h21, 20'h00102, 8'h00, 2'b00};
    rb  = {8'h5a, 20'hABCDE, 8'h0f, 2'b01};
    rc  = {8'h33, 20'h00200, 8'h01, 2'b10};
    rd  = {8'hc4, 20'h00600, 8'h02, 2'b11};
    re1 = {8'h11, 20'h00103, 8'h00, 2'b01};
    re2 = {8'hee, 20'hFFFFF, 8'hff, 2'b11};
    re3 = {8'h77, 20'h00104, 8'h03, 2'b10};
    rf  = {8'h99, 20'h00202, 8'h00, 2'b00};

    do_reset();
    chk("reset_out", 64'(outs()), 64'(O_NONE));
    chk("reset_lt", 64'(lt_now()), 64'(z));

    // Simultaneous CR/EQ pairs, round-robin, stray responses, ack+fail collision.
    tv[0]  = '{1'b1, ra, 1'b1, rb, 1'b0, 1'b0, O_NONE, z};
    tv[1]  = '{1'b0, z,  1'b0, z,  1'b1, 1'b0, O_VLD,  ra};
    tv[2]  = '{1'b0, z,  1'b0, z,  1'b0, 1'b1, O_BUSY, ra};
    tv[3]  = '{1'b0, z,  1'b0, z,  1'b1, 1'b0, O_CRA,  ra};
    tv[4]  = '{1'b0, z,  1'b0, z,  1'b0, 1'b0, O_NONE, ra};
    tv[5]  = '{1'b0, z,  1'b0, z,  1'b0, 1'b0, O_VLD,  rb};
    tv[6]  = '{1'b0, z,  1'b0, z,  1'b0, 1'b0, O_BUSY, rb};
    tv[7]  = '{1'b0, z,  1'b0, z,  1'b1, 1'b1, O_EQF,  rb};
    tv[8]  = '{1'b1, rc, 1'b1, rd, 1'b0, 1'b0, O_NONE, rb};
    tv[9]  = '{1'b0, z,  1'b0, z,  1'b0, 1'b0, O_VLD,  rc};
    tv[10] = '{1'b0, z,  1'b0, z,  1'b0, 1'b0, O_BUSY, rc};
    tv[11] = '{1'b0, z,  1'b0, z,  1'b1, 1'b0, O_CRA,  rc};
    tv[12] = '{1'b0, z,  1'b0, z,  1'b0, 1'b0, O_NONE, rc};
    tv[13] = '{1'b0, z,  1'b0, z,  1'b0, 1'b0, O_VLD,  rd};
    tv[14] = '{1'b0, z,  1'b0, z,  1'b0, 1'b0, O_BUSY, rd};
    tv[15] = '{1'b0, z,  1'b0, z,  1'b0, 1'b1, O_EQF,  rd};
    tv[16] = '{1'b0, z,  1'b0, z,  1'b0, 1'b0, O_NONE, rd};
    for (int i = 0; i < 17; i++) begin
      step($sformatf("vec%0d", i), tv[i].cv, tv[i].cr_r, tv[i].ev, tv[i].eq_r,
           tv[i].a, tv[i].f, tv[i].eo, tv[i].elt);
    end

    // Drop while pending, then a strobe on the release cycle is accepted.
    do_reset();
    step("drop_a", 1'b1, re1, 1'b0, z, 1'b0, 1'b0, O_NONE, z);
    step("drop_b", 1'b1, re2, 1'b0, z, 1'b0, 1'b0, O_VLD | O_DROP, re1);
    step("drop_c", 1'b0, z,   1'b0, z, 1'b0, 1'b0, O_BUSY, re1);
    step("drop_d", 1'b0, z,   1'b0, z, 1'b1, 1'b0, O_CRA, re1);
    step("coin_a", 1'b1, re3, 1'b0, z, 1'b0, 1'b0, O_NONE, re1);
    step("coin_b", 1'b0, z,   1'b0, z, 1'b0, 1'b0, O_VLD, re3);
    step("coin_c", 1'b0, z,   1'b0, z, 1'b0, 1'b0, O_BUSY, re3);
    step("coin_d", 1'b0, z,   1'b0, z, 1'b1, 1'b0, O_CRA, re3);
    step("coin_e", 1'b0, z,   1'b0, z, 1'b0, 1'b0, O_NONE, re3);

    // Reset during WAIT_ACK aborts silently; a late ack is ignored.
    do_reset();
    step("rst_a", 1'b1, rf, 1'b0, z, 1'b0, 1'b0, O_NONE, z);
    step("rst_b", 1'b0, z,  1'b0, z, 1'b0, 1'b0, O_VLD, rf);
    step("rst_c", 1'b0, z,  1'b0, z, 1'b0, 1'b0, O_BUSY, rf);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_out", 64'(outs()), 64'(O_NONE));
    chk("rst_lt", 64'(lt_now()), 64'(z));
    rst = 1'b0;
    step("rst_late_ack", 1'b0, z, 1'b0, z, 1'b1, 1'b0, O_NONE, z);
    step("rst_no_pend1", 1'b0, z, 1'b0, z, 1'b0, 1'b0, O_NONE, z);
    step("rst_no_pend2", 1'b0, z, 1'b0, z, 1'b0, 1'b0, O_NONE, z);

    // Unanswered transaction: local failure, or indefinite wait without the timeout.
    do_reset();
    step("to_a", 1'b0, z, 1'b1, rb, 1'b0, 1'b0, O_NONE, z);
    step("to_b", 1'b0, z, 1'b0, z,  1'b0, 1'b0, O_VLD, rb);
`ifdef LT_ARB_TIMEOUT_EN
    for (int k = 0; k < int'(TO); k++) begin
      step($sformatf("to_wait%0d", k), 1'b0, z, 1'b0, z, 1'b0, 1'b0, O_BUSY, rb);
    end
    step("to_fail", 1'b0, z, 1'b0, z, 1'b0, 1'b0, O_EQF, rb);
`else
    busy_cnt = 0;
    drive(1'b0, z, 1'b0, z, 1'b0, 1'b0);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (lt_busy === 1'b1 && outs() === O_BUSY) busy_cnt++;
    end
    chk("no_timeout_busy", 64'(busy_cnt), 64'd1000);
    step("no_timeout_ack", 1'b0, z, 1'b0, z, 1'b1, 1'b0, 7'b0001000, rb);
`endif

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(3) == 0, aux_req_t'({$urandom, $urandom}),
            $urandom_range(3) == 0, aux_req_t'({$urandom, $urandom}),
            $urandom_range(4) == 0, $urandom_range(9) == 0);
      model_step();
      @(negedge clk);
      chk($sformatf("rand%0d", c), 64'({outs(), lt_now()}),
          64'({m_vld, m_rsp, (m_age >= 0), m_drop, m_lt}));
    end

    drive(1'b0, z, 1'b0, z, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lt_aux_arbiter.md
# lt_aux_arbiter

Arbitrates the single AUX control unit transaction port between the clock recovery FSM and the channel equalization FSM during link training. Each requester's transaction is captured into a one-entry slot. Slots are granted round-robin, and one transaction at a time is forwarded to the AUX control unit. The ack or native-failure response, or a local timeout, is routed back to the owning requester. The block sits between the CR/EQ FSMs and the AUX control unit, on the 100 kHz link-training clock.

## Interface
- TIMEOUT_CYCLES, 400: cycles in WAIT_ACK before a local failure (4 ms at 100 kHz); range 2..1023.
- clk  in  1  100 kHz clock.
- rst  in  1  reset, synchronous, active-high.
- cr_data / cr_address / cr_len / cr_cmd  in  8/20/8/2  CR transaction fields.
- cr_transaction_vld  in  1  one-cycle CR request strobe.
- eq_data / eq_address / eq_len / eq_cmd  in  8/20/8/2  EQ transaction fields.
- eq_transaction_vld  in  1  one-cycle EQ request strobe.
- ctrl_ack_flag  in  1  AUX ack pulse.
- ctrl_native_failed  in  1  AUX native failure pulse.
- lt_data / lt_address / lt_len / lt_cmd  out  8/20/8/2  forwarded fields; hold until the next grant.
- lt_transaction_vld  out  1  one-cycle issue strobe.
- cr_ack_flag, cr_native_failed, eq_ack_flag, eq_native_failed  out  1  routed response pulses.
- lt_busy  out  1  high in ISSUE and WAIT_ACK.
- arb_drop  out  1  one-cycle pulse when a request is rejected.

## Operation
- Slot capture:
  - A strobe loads the fields and sets pend.
  - A strobe while that slot's pend=1 is dropped and pulses arb_drop the next cycle.
  - A strobe in the same cycle the slot is cleared is accepted, because clear happens before set.
- FSM states:
  - IDLE: if any pend=1, go to ISSUE.
  - ISSUE: register the owner's fields, drive lt_transaction_vld=1, go to WAIT_ACK.
  - WAIT_ACK: on ack, failure or timeout, pulse the owner response, clear the owner slot, return to IDLE.
- Round-robin: last_owner resets to EQ, so CR wins the first tie. With both slots pending, the grant goes to the non-last_owner. A single pending slot is granted regardless of last_owner. last_owner updates on entry to ISSUE.
- Response routing:
  - ctrl_ack_flag and ctrl_native_failed in the same cycle: failed wins, ack is suppressed.
  - Responses seen outside WAIT_ACK are ignored.
- Timeout: a 10-bit counter clears on entering WAIT_ACK and increments each WAIT_ACK cycle. At TIMEOUT_CYCLES-1 with no response, the owner native_failed pulses.
- Reset values: all outputs 0, both pend 0, state IDLE, counter 0, last_owner EQ.
- Reset mid-transaction aborts the transaction silently; no response pulse is issued.

## Timing
- Strobe at cycle N sets pend at N+1; IDLE sees it at N+1 → ISSUE at N+2 → lt_transaction_vld high during N+2 → WAIT_ACK from N+3. Request to issue takes 2 cycles.
- ctrl_ack_flag at cycle M in WAIT_ACK → owner ack pulse at M+1, IDLE at M+1, next issue no earlier than M+3.
- All outputs are registered; there are no combinational input-to-output paths.
- Back-to-back CR then EQ: the EQ issue occurs 2 cycles after the CR response pulse.

## Configuration
- LT_ARB_TIMEOUT_EN defined: the timeout counter and timeout-failure path are compiled in.
- LT_ARB_TIMEOUT_EN undefined: WAIT_ACK waits indefinitely for an AUX response, the counter is removed, and TIMEOUT_CYCLES is unused.

## Structure
- Package lt_arb_pkg:
  - state enum: IDLE, ISSUE, WAIT_ACK;
  - owner enum: OWN_CR, OWN_EQ;
  - packed struct aux_req_t {data[7:0], address[19:0], len[7:0], cmd[1:0]};
  - localparam TIMEOUT_W=10.
- Sub-module lt_arb_req_slot:
  - instantiated twice, once for CR and once for EQ;
  - contains the capture register, pend flag, drop detect and the clear-before-set rule.

## Test plan
- CR strobe, address 0x00102, data 0x21, len 0, cmd 2'b00 → lt_transaction_vld 2 cycles later with identical fields; ctrl_ack_flag → cr_ack_flag next cycle; eq outputs stay 0.
- CR and EQ strobes in the same cycle after reset → CR issued first; after its ack, EQ issued; a second simultaneous pair issues CR first again, since last_owner=EQ.
- ctrl_ack_flag and ctrl_native_failed in the same WAIT_ACK cycle for EQ → eq_native_failed=1, eq_ack_flag=0.
- Second CR strobe while CR is pending → arb_drop pulse, first fields issued unchanged; a strobe coincident with the CR response cycle → accepted and issued.
- LT_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no AUX response → owner native_failed 8 cycles after WAIT_ACK entry; without the macro → lt_busy stays high for 1000 cycles.
- rst asserted during WAIT_ACK → next cycle all outputs 0, pend cleared, and a late ctrl_ack_flag produces no response pulse.
